// File: rtl/instruction_fetch_unit.sv
// Fetch stage: holds the PC, runs a level req/ack read against instruction
// memory, presents the captured instruction to control and emits a one-cycle
// commit strobe, then registers the next PC from control's jump/branch flags.
// Optional: define FETCH_TIMEOUT_EN to add a FETCH watchdog with a sticky
// fault and a HALT state.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0040_0000,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instr_o,
    output logic [5:0]  opcode_o,
    output logic [5:0]  funct_o,
    output logic        instr_valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    input  logic        j_i,
    input  logic        jal_i,
    input  logic        jr_i,
    input  logic        branch_eq_i,
    input  logic        branch_ne_i,
    input  logic        zero_i,
    input  logic [31:0] rs_data_i,
    output logic        fault_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_EXEC  = 2'd2;
`ifdef FETCH_TIMEOUT_EN
    localparam logic [1:0] S_HALT  = 2'd3;
    localparam logic [9:0] TO_LAST = 10'(TIMEOUT_CYCLES - 1);
`endif

    logic [1:0]  state;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    logic [31:0] br_off;
    logic        br_taken;
    logic        timeout_hit;

    assign pc_plus4      = pc + 32'd4;
    assign imem_req_o    = (state == S_FETCH);
    assign imem_addr_o   = imem_req_o ? pc : 32'd0;
    assign instr_valid_o = (state == S_EXEC);
    assign instr_o       = instr;
    assign opcode_o      = instr[31:26];
    assign funct_o       = instr[5:0];
    assign pc_o          = pc;
    assign pc_plus4_o    = pc_plus4;

    assign br_off   = {{14{instr[15]}}, instr[15:0], 2'b00};
    assign br_taken = (branch_eq_i & zero_i) | (branch_ne_i & ~zero_i);

    // Next-PC select: jr beats jumps beats taken branches beats fall-through
    always_comb begin
        next_pc = pc_plus4;
        if (jr_i)
            next_pc = rs_data_i & 32'hFFFF_FFFC;
        else if (j_i | jal_i)
            next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
        else if (br_taken)
            next_pc = pc_plus4 + br_off;
    end

`ifdef FETCH_TIMEOUT_EN
    logic [9:0] to_cnt;
    logic       fault_q;

    assign timeout_hit = (state == S_FETCH) && !imem_ack_i && (to_cnt == TO_LAST);
    assign fault_o     = fault_q;

    // Watchdog: counts unacknowledged FETCH cycles, zero outside FETCH
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt  <= 10'd0;
            fault_q <= 1'b0;
        end else if (state != S_FETCH || imem_ack_i) begin
            to_cnt  <= 10'd0;
        end else if (timeout_hit) begin
            fault_q <= 1'b1;
        end else begin
            to_cnt  <= to_cnt + 10'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign fault_o     = 1'b0;
`endif

    // Fetch/commit sequencer; PC only moves at the closing edge of EXEC
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            pc    <= RESET_PC;
            instr <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (enable_i) state <= S_FETCH;
                end
                S_FETCH: begin
                    if (imem_ack_i) begin
                        instr <= imem_rdata_i;
                        state <= S_EXEC;
                    end
`ifdef FETCH_TIMEOUT_EN
                    else if (timeout_hit) begin
                        state <= S_HALT;
                    end
`endif
                end
                S_EXEC: begin
                    pc    <= next_pc;
                    state <= enable_i ? S_FETCH : S_IDLE;
                end
`ifdef FETCH_TIMEOUT_EN
                S_HALT: state <= S_HALT;
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: hand sequences for reset,
// handshake latency, enable drop, stray/late acks and the FETCH stall, plus a
// table of single fetch/commit records covering the next-PC selection.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable_i;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic        j_i, jal_i, jr_i, branch_eq_i, branch_ne_i, zero_i;
    logic [31:0] rs_data_i;

    logic        imem_req_o, instr_valid_o, fault_o;
    logic [31:0] imem_addr_o, instr_o, pc_o, pc_plus4_o;
    logic [5:0]  opcode_o, funct_o;

    logic        w_req, w_valid, w_fault;
    logic [31:0] w_addr, w_instr, w_pc, w_pc4;
    logic [5:0]  w_opcode, w_funct;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instruction_fetch_unit dut (
        .clk(clk), .reset(reset), .enable_i(enable_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i),
        .instr_o(instr_o), .opcode_o(opcode_o), .funct_o(funct_o),
        .instr_valid_o(instr_valid_o), .pc_o(pc_o), .pc_plus4_o(pc_plus4_o),
        .j_i(j_i), .jal_i(jal_i), .jr_i(jr_i),
        .branch_eq_i(branch_eq_i), .branch_ne_i(branch_ne_i),
        .zero_i(zero_i), .rs_data_i(rs_data_i), .fault_o(fault_o)
    );

    // Second instance starting at the top of the address space (wrap check)
    instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .reset(reset), .enable_i(enable_i),
        .imem_req_o(w_req), .imem_addr_o(w_addr),
        .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i),
        .instr_o(w_instr), .opcode_o(w_opcode), .funct_o(w_funct),
        .instr_valid_o(w_valid), .pc_o(w_pc), .pc_plus4_o(w_pc4),
        .j_i(j_i), .jal_i(jal_i), .jr_i(jr_i),
        .branch_eq_i(branch_eq_i), .branch_ne_i(branch_ne_i),
        .zero_i(zero_i), .rs_data_i(rs_data_i), .fault_o(w_fault)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        j, jal, jr, beq, bne, zero;
        logic [31:0] rs;
        logic [31:0] nxt;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic clear_flags();
        j_i = 0; jal_i = 0; jr_i = 0; branch_eq_i = 0; branch_ne_i = 0;
        zero_i = 0; rs_data_i = 32'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //            pc            instr          j  jal jr beq bne z  rs            next
        tbl[0] = '{32'h0040_0004, 32'h0000_0000, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0040_0008};
        tbl[1] = '{32'h0040_0008, 32'h1000_FFFF, 0, 0, 0, 1, 0, 1, 32'h0,         32'h0040_0008};
        tbl[2] = '{32'h0040_0008, 32'h1400_0003, 0, 0, 0, 0, 1, 0, 32'h0,         32'h0040_0018};
        tbl[3] = '{32'h0040_0018, 32'h1000_FFFF, 0, 0, 0, 1, 0, 0, 32'h0,         32'h0040_001C};
        tbl[4] = '{32'h0040_001C, 32'h1400_0003, 0, 0, 0, 0, 1, 1, 32'h0,         32'h0040_0020};
        tbl[5] = '{32'h0040_0020, 32'h0810_0010, 1, 0, 0, 0, 0, 0, 32'h0,         32'h0040_0040};
        tbl[6] = '{32'h0040_0040, 32'h0C10_0010, 0, 1, 0, 0, 0, 0, 32'h0,         32'h0040_0040};
        tbl[7] = '{32'h0040_0040, 32'h0000_0008, 0, 0, 1, 0, 0, 0, 32'h0040_0023, 32'h0040_0020};
        tbl[8] = '{32'h0040_0020, 32'h1000_FFFF, 0, 0, 1, 1, 0, 1, 32'h0040_0104, 32'h0040_0104};
        tbl[9] = '{32'h0040_0104, 32'h0000_0020, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0040_0108};

        reset = 1; enable_i = 0; imem_ack_i = 0; imem_rdata_i = 32'd0;
        clear_flags();
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_pc", pc_o, 32'h0040_0000);
        chk("rst_req", imem_req_o, 1'b0);
        chk("rst_addr", imem_addr_o, 32'd0);
        chk("rst_valid", instr_valid_o, 1'b0);
        chk("rst_instr", instr_o, 32'd0);
        chk("rst_fault", fault_o, 1'b0);
        chk("rst_pc_w", w_pc, 32'hFFFF_FFFC);

        // First fetch, ack two cycles after req rises
        reset = 0;
        @(negedge clk); chk("idle_req", imem_req_o, 1'b0);
        enable_i = 1;
        @(negedge clk);
        chk("f1_req", imem_req_o, 1'b1);
        chk("f1_addr", imem_addr_o, 32'h0040_0000);
        chk("f1_valid", instr_valid_o, 1'b0);
        @(negedge clk);
        chk("f1_hold_req", imem_req_o, 1'b1);
        chk("f1_hold_valid", instr_valid_o, 1'b0);
        imem_ack_i = 1; imem_rdata_i = 32'h0000_0000;
        @(negedge clk);
        imem_ack_i = 0;
        chk("f1_valid_pulse", instr_valid_o, 1'b1);
        chk("f1_req_exec", imem_req_o, 1'b0);
        chk("w_pc4_wrap", w_pc4, 32'h0000_0000);
        @(negedge clk);
        chk("f1_valid_end", instr_valid_o, 1'b0);
        chk("f1_next_addr", imem_addr_o, 32'h0040_0004);
        chk("w_next_pc", w_pc, 32'h0000_0000);
        chk("w_next_addr", w_addr, 32'h0000_0000);
        chk("w_next_req", w_req, 1'b1);

        // Table: one immediate-ack fetch + commit per record
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("v%0d_addr", i), imem_addr_o, tbl[i].pc);
            chk($sformatf("v%0d_req", i), imem_req_o, 1'b1);
            imem_ack_i = 1; imem_rdata_i = tbl[i].instr;
            @(negedge clk);
            imem_ack_i = 0;
            chk($sformatf("v%0d_valid", i), instr_valid_o, 1'b1);
            chk($sformatf("v%0d_opcode", i), {26'd0, opcode_o}, {26'd0, tbl[i].instr[31:26]});
            chk($sformatf("v%0d_funct", i), {26'd0, funct_o}, {26'd0, tbl[i].instr[5:0]});
            chk($sformatf("v%0d_pc4", i), pc_plus4_o, tbl[i].pc + 32'd4);
            j_i = tbl[i].j; jal_i = tbl[i].jal; jr_i = tbl[i].jr;
            branch_eq_i = tbl[i].beq; branch_ne_i = tbl[i].bne;
            zero_i = tbl[i].zero; rs_data_i = tbl[i].rs;
            @(negedge clk);
            clear_flags();
            chk($sformatf("v%0d_next", i), pc_o, tbl[i].nxt);
            chk($sformatf("v%0d_valid_end", i), instr_valid_o, 1'b0);
        end

        // Enable drops mid-FETCH: handshake finishes, one commit, then IDLE
        enable_i = 0;
        j_i = 1; jr_i = 1; rs_data_i = 32'h1234_5678;   // ignored outside EXEC
        @(negedge clk);
        clear_flags();
        chk("ed_req_held", imem_req_o, 1'b1);
        chk("ed_pc_held", pc_o, 32'h0040_0108);
        imem_ack_i = 1; imem_rdata_i = 32'h0000_0020;
        @(negedge clk);
        imem_ack_i = 0;
        chk("ed_valid", instr_valid_o, 1'b1);
        @(negedge clk);
        chk("ed_valid_end", instr_valid_o, 1'b0);
        chk("ed_req_idle", imem_req_o, 1'b0);
        chk("ed_pc", pc_o, 32'h0040_010C);
        repeat (3) @(negedge clk);
        chk("ed_stay_idle", imem_req_o, 1'b0);

        // Stray ack in IDLE leaves the instruction register alone
        imem_ack_i = 1; imem_rdata_i = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_ack_i = 0;
        chk("idle_ack_instr", instr_o, 32'h0000_0020);
        chk("idle_ack_valid", instr_valid_o, 1'b0);
        chk("idle_ack_req", imem_req_o, 1'b0);

        // Reset mid-FETCH, then a late ack after release
        enable_i = 1;
        @(negedge clk);
        chk("rf_req", imem_req_o, 1'b1);
        reset = 1; enable_i = 0;
        #1;
        chk("rf_req_drop", imem_req_o, 1'b0);
        chk("rf_pc", pc_o, 32'h0040_0000);
        chk("rf_instr", instr_o, 32'd0);
        @(negedge clk);
        reset = 0; imem_ack_i = 1; imem_rdata_i = 32'hFFFF_FFFF;
        @(negedge clk);
        imem_ack_i = 0;
        chk("late_ack_instr", instr_o, 32'd0);
        chk("late_ack_valid", instr_valid_o, 1'b0);
        chk("late_ack_req", imem_req_o, 1'b0);

        // FETCH with no ack
        enable_i = 1;
        @(negedge clk);
        chk("st_req", imem_req_o, 1'b1);
        repeat (20) @(negedge clk);
`ifdef FETCH_TIMEOUT_EN
        chk("to_fault", fault_o, 1'b1);
        chk("to_req", imem_req_o, 1'b0);
        chk("to_valid", instr_valid_o, 1'b0);
        chk("to_pc", pc_o, 32'h0040_0000);
        imem_ack_i = 1;
        repeat (3) @(negedge clk);
        imem_ack_i = 0;
        chk("to_sticky", fault_o, 1'b1);
        chk("to_req_sticky", imem_req_o, 1'b0);
`else
        chk("st_req_held", imem_req_o, 1'b1);
        chk("st_addr", imem_addr_o, 32'h0040_0000);
        chk("st_fault", fault_o, 1'b0);
        chk("st_valid", instr_valid_o, 1'b0);
`endif
        reset = 1;
        #1;
        chk("end_fault_clr", fault_o, 1'b0);
        chk("end_req", imem_req_o, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
